// File: rtl/sorted_block_merger_if.sv
// Handshake bundle for sorted_block_merger: two 4-element input blocks plus the
// merged output stream. "slave" is the merger side, "master" is the surrounding logic.
interface sorted_block_merger_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] a1, a2, a3, a4;
  logic [N-1:0] b1, b2, b3, b4;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport slave (
    input  a1, a2, a3, a4, b1, b2, b3, b4, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output a1, a2, a3, a4, b1, b2, b3, b4, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sorted_block_merger.sv
// Merges two ascending 4-element blocks into one 8-beat ascending stream.
// Define MERGE_B2B_EN to accept the next block pair on the final beat (no idle bubble).
module sorted_block_merger #(
  parameter int unsigned N = 8
) (
  input logic                  clk,
  input logic                  rst,
  sorted_block_merger_if.slave io
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t       state;
  logic [N-1:0] bank_a [4];
  logic [N-1:0] bank_b [4];
  logic [2:0]   ptr_a, ptr_b, cnt;
  logic [N-1:0] head_a, head_b;
  logic         sel_a, fire, load;

  // Pointer bit 2 marks an exhausted bank; ties favour A to keep the merge stable.
  always_comb begin
    head_a = bank_a[ptr_a[1:0]];
    head_b = bank_b[ptr_b[1:0]];
    if (ptr_a[2])      sel_a = 1'b0;
    else if (ptr_b[2]) sel_a = 1'b1;
    else               sel_a = (head_a <= head_b);
  end

  assign io.out_valid = (state == MERGE);
  assign io.out_last  = (state == MERGE) && (cnt == 3'd7);
  assign io.out_data  = (state == MERGE) ? (sel_a ? head_a : head_b) : '0;
  assign fire         = io.out_valid & io.out_ready;

`ifdef MERGE_B2B_EN
  assign io.in_ready = (state == IDLE) | (fire & io.out_last);
`else
  assign io.in_ready = (state == IDLE);
`endif

  assign load = io.in_valid & io.in_ready;

  // A load coinciding with the last beat takes priority and restarts MERGE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr_a <= '0;
      ptr_b <= '0;
      cnt   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (load) begin
      bank_a[0] <= io.a1;
      bank_a[1] <= io.a2;
      bank_a[2] <= io.a3;
      bank_a[3] <= io.a4;
      bank_b[0] <= io.b1;
      bank_b[1] <= io.b2;
      bank_b[2] <= io.b3;
      bank_b[3] <= io.b4;
      ptr_a     <= '0;
      ptr_b     <= '0;
      cnt       <= '0;
      state     <= MERGE;
    end else if (fire) begin
      if (sel_a) ptr_a <= ptr_a + 3'd1;
      else       ptr_b <= ptr_b + 3'd1;
      cnt <= cnt + 3'd1;
      if (io.out_last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_sorted_block_merger.sv
// Directed bench for sorted_block_merger: hand-computed merge sequences, backpressure,
// tie ordering, async reset mid-merge and back-to-back pairs (both MERGE_B2B_EN builds).
module tb_sorted_block_merger;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_seq [8];

  sorted_block_merger_if #(.N(8)) bus ();

  sorted_block_merger #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_exp(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    exp_seq[0] = e0; exp_seq[1] = e1; exp_seq[2] = e2; exp_seq[3] = e3;
    exp_seq[4] = e4; exp_seq[5] = e5; exp_seq[6] = e6; exp_seq[7] = e7;
  endtask

  task automatic drive_pair(input logic [7:0] x1, x2, x3, x4, y1, y2, y3, y4);
    bus.a1 = x1; bus.a2 = x2; bus.a3 = x3; bus.a4 = x4;
    bus.b1 = y1; bus.b2 = y2; bus.b3 = y3; bus.b4 = y4;
  endtask

  // Present a pair for exactly one capture edge from IDLE.
  task automatic load(input logic [7:0] x1, x2, x3, x4, y1, y2, y3, y4);
    @(negedge clk);
    drive_pair(x1, x2, x3, x4, y1, y2, y3, y4);
    bus.in_valid = 1'b1;
    check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // bp: out_ready pattern 1,0,0,...; poke: in_valid pulses during MERGE; tie: pointer monitor.
  task automatic collect(input bit bp, input bit poke, input bit tie);
    int beat = 0;
    bit stalled = 1'b0;
    logic [7:0] held = '0;
    for (int cyc = 0; cyc < 60 && beat < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      check("out_valid", bus.out_valid, 1);
      if (stalled) check("hold", bus.out_data, held);
      check("out_data", bus.out_data, exp_seq[beat]);
      check("out_last", bus.out_last, (beat == 7));
      if (tie) begin
        check("ptr_a", dut.ptr_a, (beat < 4) ? beat : 4);
        check("ptr_b", dut.ptr_b, (beat < 4) ? 0 : beat - 4);
      end
      if (poke && !bus.out_last) begin
        check("in_ready_merge", bus.in_ready, 0);
        drive_pair(8'd99, 8'd99, 8'd99, 8'd99, 8'd0, 8'd0, 8'd0, 8'd0);
        bus.in_valid = (cyc % 2 == 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      held    = bus.out_data;
      stalled = !bus.out_ready;
      if (bus.out_ready) beat++;
    end
    check("beats", beat, 8);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
  endtask

  initial begin
    int beat;
    int gaps;
    int sent;
    bit pending;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_pair(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk) rst = 1'b0;
    check_idle("idle0");

    // Interleaved merge
    load(8'd1, 8'd4, 8'd6, 8'd9, 8'd2, 8'd3, 8'd7, 8'd8);
    set_exp(8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9);
    collect(1'b0, 1'b0, 1'b0);
    check_idle("after_interleave");

    // Ties: all A first, then all B
    load(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    set_exp(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    collect(1'b0, 1'b0, 1'b1);

    // Disjoint ranges, B entirely below A
    load(8'd200, 8'd201, 8'd202, 8'd203, 8'd0, 8'd1, 8'd2, 8'd3);
    set_exp(8'd0, 8'd1, 8'd2, 8'd3, 8'd200, 8'd201, 8'd202, 8'd203);
    collect(1'b0, 1'b0, 1'b0);

    // Backpressure with in_valid pokes during MERGE
    load(8'd10, 8'd20, 8'd30, 8'd40, 8'd15, 8'd25, 8'd35, 8'd45);
    set_exp(8'd10, 8'd15, 8'd20, 8'd25, 8'd30, 8'd35, 8'd40, 8'd45);
    collect(1'b1, 1'b1, 1'b0);
    check_idle("after_bp");

    // Async reset after 3 beats, asserted between clock edges
    load(8'd11, 8'd12, 8'd13, 8'd14, 8'd21, 8'd22, 8'd23, 8'd24);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_last", bus.out_last, 0);
    check("arst_out_data", bus.out_data, 0);
    @(negedge clk) rst = 1'b0;
    load(8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd2);
    set_exp(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2);
    collect(1'b0, 1'b0, 1'b0);

    // Back-to-back pairs with in_valid held high
    check_idle("pre_b2b");
    bus.out_ready = 1'b1;
    drive_pair(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    bus.in_valid = 1'b1;
    beat = 0; gaps = 0; sent = 0; pending = 1'b0;
    for (int cyc = 0; cyc < 60 && beat < 16; cyc++) begin
      logic [7:0] want;
      if (cyc > 0) @(negedge clk);
      if (pending) begin
        sent++;
        if (sent == 1) drive_pair(8'd10, 8'd30, 8'd50, 8'd70, 8'd20, 8'd40, 8'd60, 8'd80);
        else           bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        want = (beat < 8) ? 8'(beat + 1) : 8'((beat - 7) * 10);
        check("b2b_data", bus.out_data, want);
        check("b2b_last", bus.out_last, (beat == 7 || beat == 15));
        beat++;
      end else if (beat == 8) begin
        gaps++;
      end
      pending = bus.in_valid && bus.in_ready;
    end
    check("b2b_beats", beat, 16);
    check("b2b_pairs", sent, 2);
`ifdef MERGE_B2B_EN
    check("b2b_gap", gaps, 0);
`else
    check("b2b_gap", gaps, 1);
`endif
    bus.in_valid = 1'b0;
    check_idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sorted_block_merger.md
Name: sorted_block_merger

Overview:
- Consumer end of the 4-input odd-even sorting network.
- Accepts two independently sorted 4-element blocks (A and B), e.g. from two sorter instances.
- Merges them into one ascending sequence of 8 elements.
- Streams the result one element per beat over a valid/ready interface, with a last flag on the 8th beat.

Parameters:
- N, 8, width in bits of each unsigned element.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a1, a2, a3, a4  input  N each  block A; ascending order required (a1 <= a2 <= a3 <= a4).
- b1, b2, b3, b4  input  N each  block B; ascending order required.
- in_valid  input  1  blocks A/B are presented.
- in_ready  output  1  merger can capture a new pair of blocks.
- out_data  output  N  current merged element.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks the 8th (final) element of the merged sequence.

Behaviour:
- Interface is fixed: one clock clk; reset rst is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0. State=IDLE; ptr_a=0, ptr_b=0, cnt=0; bank registers cleared to 0.
- States: IDLE, MERGE.
- IDLE:
  - in_ready=1, out_valid=0, out_data=0.
  - On in_valid&in_ready: capture a1..a4 into bank A and b1..b4 into bank B; set ptr_a=0, ptr_b=0, cnt=0; go to MERGE.
- MERGE:
  - in_ready=0 (exception under MERGE_B2B_EN), out_valid=1.
  - Head values: headA = A[ptr_a] if ptr_a<4, else exhausted; headB likewise.
  - out_data selection, combinational from registered state:
    - both heads present: headA if headA <= headB (tie goes to A, stable), else headB;
    - one bank exhausted: head of the other bank.
  - out_last = (cnt==7).
  - On out_valid&out_ready: advance the pointer of the selected bank; cnt <= cnt+1. If out_last, go to IDLE.
  - Without a handshake, out_data, out_valid and out_last stay stable; all state holds.
- Widths:
  - ptr_a and ptr_b are 3 bits (0..4); cnt is 3 bits.
  - Comparison is unsigned N-bit; no arithmetic overflow is possible.
- Latency:
  - Capture at edge k gives the first out_valid in cycle k+1.
  - With out_ready held high, 8 beats are output in cycles k+1..k+8.
  - Without MERGE_B2B_EN, the next capture is possible at the earliest in IDLE cycle k+9, so throughput is 9 cycles per block pair.
- Boundary conditions:
  - in_valid while in MERGE: ignored (in_ready=0); the source must hold its data.
  - Equal elements across banks: A is emitted first.
  - All of A smaller than all of B: output is a1..a4 then b1..b4.
  - Exhaustion of one bank before cnt==7 is handled by the "other head" rule.
  - Unsorted input blocks: behaviour is defined (the same pointer rules apply) but the output is not guaranteed sorted.
  - rst asserted mid-MERGE: immediately returns to the reset values; the partial sequence is discarded; no out_last is issued.
  - out_ready low for any number of cycles: the output holds indefinitely.

Optional Feature:
- Macro: MERGE_B2B_EN.
- Defined:
  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
  - A capture coinciding with the last beat reloads the banks and stays in MERGE with ptr_a=ptr_b=cnt=0.
  - Sustained throughput is 8 cycles per pair, with no bubble between sequences.
- Undefined: in_ready = (state==IDLE) only, so there is one idle bubble between sequences.

Test Plan:
- Interleaved merge: A={1,4,6,9}, B={2,3,7,8}, out_ready=1 -> out_data 1,2,3,4,6,7,8,9 on consecutive cycles; out_last only on 9; in_ready=1 the cycle after.
- Ties and stability: A={5,5,5,5}, B={5,5,5,5}; tag via a monitor of the pointer source -> four A-sourced beats, then four B-sourced beats; all values 5.
- Disjoint ranges: A={200,201,202,203}, B={0,1,2,3} -> 0,1,2,3,200,201,202,203.
- Backpressure: A={10,20,30,40}, B={15,25,35,45}; out_ready toggles 1,0,0,1,... -> out_data is held stable while out_ready=0; full sequence 10,15,20,25,30,35,40,45 with no loss or duplication; in_valid pulses during MERGE are ignored.
- Async reset mid-merge: assert rst after 3 beats (between clock edges) -> out_valid=0 and in_ready=1 immediately; a subsequent new pair A={0,0,0,1}, B={0,0,0,2} streams 0,0,0,0,0,0,1,2 correctly.
- MERGE_B2B_EN: two back-to-back pairs with in_valid held high -> 16 consecutive valid beats, out_last on beats 8 and 16; without the macro, a single out_valid=0 cycle between beats 8 and 9.
